// File: rtl/button_debounce.sv
// Debounces one raw active-low push-button into a clean level plus one-cycle
// press/release strobes. Also emits the slow sample strobe (TICK) used as a clock enable.
module button_debounce #(
  parameter int DIV_W    = 12,
  parameter int DB_TICKS = 244,
  parameter int DB_W     = 8
) (
  input  logic CLK,
  input  logic RST,
  input  logic BUT_N,
  output logic BUT_DB_N,
  output logic PRESS,
  output logic RELEASE,
  output logic TICK
);

  if (DB_TICKS < 2 || DB_TICKS > (2**DB_W) - 1) begin : g_bad_db_ticks
    $error("button_debounce: DB_TICKS=%0d outside legal range 2..%0d", DB_TICKS, (2**DB_W) - 1);
  end

  typedef enum logic [1:0] {
    RELEASED,
    PRESS_WAIT,
    PRESSED,
    RELEASE_WAIT
  } state_t;

  localparam logic [DB_W-1:0]  CNT_LAST = DB_W'(DB_TICKS - 1);
  localparam logic [DB_W-1:0]  CNT_ONE  = DB_W'(1);
  localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);

  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic             tick_q, tick_d;
  state_t           state_q, state_d;
  logic [DB_W-1:0]  cnt_q, cnt_d;
  logic             db_n_q, db_n_d;
  logic             press_q, press_d;
  logic             release_q, release_d;

  // NOTE: every signal gets a default before the case so no path can infer a latch.
  always_comb begin
    sync1_d   = BUT_N;
    sync2_d   = sync1_q;
    div_d     = div_q + DIV_ONE;
    tick_d    = &div_q;
    state_d   = state_q;
    cnt_d     = cnt_q;
    db_n_d    = db_n_q;
    press_d   = 1'b0;
    release_d = 1'b0;

    if (tick_q) begin
      unique case (state_q)
        RELEASED: begin
          if (!sync2_q) begin
            state_d = PRESS_WAIT;
            cnt_d   = CNT_ONE;
          end
        end
        PRESS_WAIT: begin
          // The sample on the accepting tick is decisive: a high there aborts.
          if (sync2_q) begin
            state_d = RELEASED;
            cnt_d   = '0;
          end else if (cnt_q == CNT_LAST) begin
            state_d = PRESSED;
            cnt_d   = '0;
            db_n_d  = 1'b0;
            press_d = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
        PRESSED: begin
          if (sync2_q) begin
            state_d = RELEASE_WAIT;
            cnt_d   = CNT_ONE;
          end
        end
        RELEASE_WAIT: begin
          if (!sync2_q) begin
            state_d = PRESSED;
            cnt_d   = '0;
          end else if (cnt_q == CNT_LAST) begin
            state_d   = RELEASED;
            cnt_d     = '0;
            db_n_d    = 1'b1;
            release_d = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
        default: begin
          state_d = RELEASED;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge CLK) begin
    if (RST) begin
      sync1_q   <= 1'b1;
      sync2_q   <= 1'b1;
      div_q     <= '0;
      tick_q    <= 1'b0;
      state_q   <= RELEASED;
      cnt_q     <= '0;
      db_n_q    <= 1'b1;
      press_q   <= 1'b0;
      release_q <= 1'b0;
    end else begin
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      div_q     <= div_d;
      tick_q    <= tick_d;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      db_n_q    <= db_n_d;
      press_q   <= press_d;
      release_q <= release_d;
    end
  end

  assign BUT_DB_N = db_n_q;
  assign PRESS    = press_q;
  assign RELEASE  = release_q;
  assign TICK     = tick_q;

endmodule

// File: tb/tb_button_debounce.sv
// Directed bench for button_debounce with DIV_W=4 (TICK every 16 CLK), DB_TICKS=4, DB_W=3.
// Each task drives one scenario and compares outputs against hand-derived values.
module tb_button_debounce;

  logic CLK = 1'b0;
  logic RST;
  logic BUT_N;
  logic BUT_DB_N, PRESS, RELEASE, TICK;

  int compared   = 0;
  int mismatched = 0;
  int press_seen   = 0;
  int release_seen = 0;

  button_debounce #(.DIV_W(4), .DB_TICKS(4), .DB_W(3)) dut (
    .CLK     (CLK),
    .RST     (RST),
    .BUT_N   (BUT_N),
    .BUT_DB_N(BUT_DB_N),
    .PRESS   (PRESS),
    .RELEASE (RELEASE),
    .TICK    (TICK)
  );

  always #5 CLK = ~CLK;

  // Strobe counters sampled on posedge so they never race the negedge checks.
  always @(posedge CLK) begin
    if (PRESS === 1'b1)   press_seen++;
    if (RELEASE === 1'b1) release_seen++;
  end

  // Wait for the next TICK cycle, then step one more CLK and sample the registered outputs.
  task automatic tick_step(output logic p, output logic r, output logic db);
    int n;
    n = 0;
    @(negedge CLK);
    while (TICK !== 1'b1 && n < 40) begin
      @(negedge CLK);
      n++;
    end
    if (TICK !== 1'b1) begin
      compared++;
      mismatched++;
      $display("FAIL tick_timeout: no TICK within %0d CLK", n);
    end
    @(negedge CLK);
    p  = PRESS;
    r  = RELEASE;
    db = BUT_DB_N;
  endtask

  task automatic test_reset();
    int n;
    RST   = 1'b1;
    BUT_N = 1'b0;
    repeat (3) @(negedge CLK);
    compared++; if (BUT_DB_N !== 1'b1) begin mismatched++; $display("FAIL reset_db: got %b want 1", BUT_DB_N); end
    compared++; if (PRESS !== 1'b0)    begin mismatched++; $display("FAIL reset_press: got %b want 0", PRESS); end
    compared++; if (RELEASE !== 1'b0)  begin mismatched++; $display("FAIL reset_release: got %b want 0", RELEASE); end
    compared++; if (TICK !== 1'b0)     begin mismatched++; $display("FAIL reset_tick: got %b want 0", TICK); end
    RST   = 1'b0;
    BUT_N = 1'b1;
    n = 0;
    do begin
      @(negedge CLK);
      n++;
    end while (TICK !== 1'b1 && n < 40);
    compared++; if (n != 16) begin mismatched++; $display("FAIL first_tick: got %0d CLK want 16", n); end
    @(negedge CLK);
  endtask

  task automatic test_press();
    logic p, r, db;
    int r0;
    r0 = release_seen;
    BUT_N = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      tick_step(p, r, db);
      compared++; if (p !== (i == 4)) begin mismatched++; $display("FAIL press_p%0d: got %b want %b", i, p, (i == 4)); end
      compared++; if (db !== (i != 4)) begin mismatched++; $display("FAIL press_db%0d: got %b want %b", i, db, (i != 4)); end
      compared++; if (r !== 1'b0) begin mismatched++; $display("FAIL press_r%0d: got %b want 0", i, r); end
    end
    @(negedge CLK);
    compared++; if (PRESS !== 1'b0) begin mismatched++; $display("FAIL press_width: got %b want 0", PRESS); end
    compared++; if (release_seen != r0) begin mismatched++; $display("FAIL press_no_release: got %0d want %0d", release_seen, r0); end
  endtask

  task automatic test_release();
    logic p, r, db;
    BUT_N = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      tick_step(p, r, db);
      compared++; if (r !== (i == 4)) begin mismatched++; $display("FAIL release_r%0d: got %b want %b", i, r, (i == 4)); end
      compared++; if (db !== (i == 4)) begin mismatched++; $display("FAIL release_db%0d: got %b want %b", i, db, (i == 4)); end
      compared++; if (p !== 1'b0) begin mismatched++; $display("FAIL release_p%0d: got %b want 0", i, p); end
    end
    @(negedge CLK);
    compared++; if (RELEASE !== 1'b0) begin mismatched++; $display("FAIL release_width: got %b want 0", RELEASE); end
  endtask

  task automatic test_glitch();
    logic p, r, db;
    int p0, r0;
    tick_step(p, r, db);
    p0 = press_seen;
    r0 = release_seen;
    repeat (3) @(negedge CLK);
    BUT_N = 1'b0;
    repeat (5) @(negedge CLK);
    BUT_N = 1'b1;
    for (int i = 1; i <= 2; i++) begin
      tick_step(p, r, db);
      compared++; if (db !== 1'b1) begin mismatched++; $display("FAIL glitch_db%0d: got %b want 1", i, db); end
    end
    compared++; if (press_seen != p0)   begin mismatched++; $display("FAIL glitch_press: got %0d want %0d", press_seen, p0); end
    compared++; if (release_seen != r0) begin mismatched++; $display("FAIL glitch_release: got %0d want %0d", release_seen, r0); end
  endtask

  task automatic test_bounce_press();
    logic p, r, db;
    bit lv  [7] = '{0, 0, 1, 0, 0, 0, 0};
    bit exp [7] = '{0, 0, 0, 0, 0, 0, 1};
    for (int i = 0; i < 7; i++) begin
      BUT_N = lv[i];
      tick_step(p, r, db);
      compared++; if (p !== exp[i]) begin mismatched++; $display("FAIL bounce_p%0d: got %b want %b", i, p, exp[i]); end
      compared++; if (db !== !exp[i]) begin mismatched++; $display("FAIL bounce_db%0d: got %b want %b", i, db, !exp[i]); end
    end
  endtask

  task automatic test_release_abort();
    logic p, r, db;
    bit lv [5] = '{1, 1, 1, 0, 0};
    for (int i = 0; i < 5; i++) begin
      BUT_N = lv[i];
      tick_step(p, r, db);
      compared++; if (r !== 1'b0) begin mismatched++; $display("FAIL rabort_r%0d: got %b want 0", i, r); end
      compared++; if (db !== 1'b0) begin mismatched++; $display("FAIL rabort_db%0d: got %b want 0", i, db); end
    end
  endtask

  task automatic test_reset_mid_debounce();
    logic p, r, db;
    int p0;
    BUT_N = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      tick_step(p, r, db);
      compared++; if (r !== (i == 4)) begin mismatched++; $display("FAIL rmid_rel%0d: got %b want %b", i, r, (i == 4)); end
    end
    BUT_N = 1'b0;
    p0 = press_seen;
    repeat (3) tick_step(p, r, db);
    RST = 1'b1;
    repeat (3) @(negedge CLK);
    compared++; if (BUT_DB_N !== 1'b1) begin mismatched++; $display("FAIL rmid_db: got %b want 1", BUT_DB_N); end
    compared++; if (TICK !== 1'b0)     begin mismatched++; $display("FAIL rmid_tick: got %b want 0", TICK); end
    RST = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      tick_step(p, r, db);
      compared++; if (p !== (i == 4)) begin mismatched++; $display("FAIL rmid_p%0d: got %b want %b", i, p, (i == 4)); end
      compared++; if (db !== (i != 4)) begin mismatched++; $display("FAIL rmid_db%0d: got %b want %b", i, db, (i != 4)); end
    end
    @(negedge CLK);
    compared++; if (press_seen != p0 + 1) begin mismatched++; $display("FAIL rmid_press_count: got %0d want %0d", press_seen, p0 + 1); end
  endtask

  initial begin
    RST   = 1'b1;
    BUT_N = 1'b1;
    test_reset();
    test_press();
    test_release();
    test_glitch();
    test_bounce_press();
    test_release_abort();
    test_reset_mid_debounce();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
